// File: rtl/fetch_if.sv
// Fetch unit bus bundle: redirect input, instruction RAM port, decode handshake and occupancy.
// Optional perf counter outputs are present only when FETCH_PERF_EN is defined.
interface fetch_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 2
);
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic              out_ready;
   logic [CNT_W-1:0]  fifo_count;
`ifdef FETCH_PERF_EN
   logic [31:0]       perf_fetched;
   logic [31:0]       perf_flushed;
   logic [31:0]       perf_stall;

   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count,
      output perf_fetched, perf_flushed, perf_stall
   );
   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count,
      input  perf_fetched, perf_flushed, perf_stall
   );
`else
   modport master (
      input  redirect_valid, redirect_pc, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count
   );
   modport slave (
      output redirect_valid, redirect_pc, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, fifo_count
   );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a registered-output instruction RAM, buffers
// returned words in a DEPTH-entry FIFO and hands {pc, instr} to decode over valid/ready.
// Redirects flush the FIFO and toggle an epoch so stale responses are dropped.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_flushed/perf_stall counters.
module fetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic     clock,
   input logic     clear,
   fetch_if.master bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          inflight_epoch_q, inflight_epoch_d;
   logic          epoch_q, epoch_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   mem_pc_q    [DEPTH];
   logic [31:0]   mem_instr_q [DEPTH];

   logic          out_valid;
   logic          pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occ;

   // Handshake, credit-based issue decision and outputs
   always_comb begin
      out_valid = (count_q != '0);
      pop       = out_valid && bus.out_ready;
      // A matching response is lost if a redirect flushes on the same edge
      push      = inflight_q && (inflight_epoch_q == epoch_q) && !bus.redirect_valid;
      // Occupancy after this edge plus the in-flight slot must leave room for the new request
      occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
      issue     = !clear && !bus.redirect_valid && (occ < DEPTH_W);

      bus.imem_req   = issue;
      bus.imem_addr  = pc_q[ADDR_W-1:0];
      bus.out_valid  = out_valid;
      bus.out_pc     = out_valid ? mem_pc_q[rd_ptr_q] : '0;
      bus.out_instr  = out_valid ? mem_instr_q[rd_ptr_q] : '0;
      bus.fifo_count = count_q;
   end

   // Next-state for PC, in-flight tracking, epoch and FIFO pointers
   always_comb begin
      pc_d             = pc_q;
      inflight_d       = issue;
      inflight_pc_d    = inflight_pc_q;
      inflight_epoch_d = inflight_epoch_q;
      epoch_d          = epoch_q;
      count_d          = count_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      if (issue) begin
         inflight_pc_d    = pc_q;
         inflight_epoch_d = epoch_q;
         pc_d             = pc_q + 32'd4;
      end
      if (bus.redirect_valid) begin
         pc_d     = bus.redirect_pc & ~32'h3;
         epoch_d  = ~epoch_q;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with asynchronous clear
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         pc_q             <= RESET_PC;
         inflight_q       <= 1'b0;
         inflight_pc_q    <= '0;
         inflight_epoch_q <= 1'b0;
         epoch_q          <= 1'b0;
         count_q          <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
      end else begin
         pc_q             <= pc_d;
         inflight_q       <= inflight_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_epoch_q <= inflight_epoch_d;
         epoch_q          <= epoch_d;
         count_q          <= count_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are only observed through count, so no reset needed
   always_ff @(posedge clock) begin
      if (push) begin
         mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
         mem_instr_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_flushed_q, perf_stall_q;
   logic [31:0] flushed_inc;

   // Entries discarded by a redirect plus any in-flight response that will not be pushed
   always_comb begin
      flushed_inc = 32'(inflight_q && !push);
      if (bus.redirect_valid) flushed_inc = flushed_inc + 32'(count_q - CW'(pop));
      bus.perf_fetched = perf_fetched_q;
      bus.perf_flushed = perf_flushed_q;
      bus.perf_stall   = perf_stall_q;
   end

   // Wrapping event counters
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_q + 32'(push);
         perf_flushed_q <= perf_flushed_q + flushed_inc;
         perf_stall_q   <= perf_stall_q + 32'(out_valid && !bus.out_ready);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (DEPTH=2, DEPTH=4, wrapping RESET_PC)
// each fed by a registered-read instruction RAM model.
module tb_fetch_unit;
   logic clock;
   logic clear;
   int   vectors;
   int   miscompares;

   fetch_if #(.ADDR_W(8), .CNT_W(2)) a_if ();
   fetch_if #(.ADDR_W(8), .CNT_W(3)) b_if ();
   fetch_if #(.ADDR_W(8), .CNT_W(2)) c_if ();

   fetch_unit #(.DEPTH(2), .ADDR_W(8), .RESET_PC(32'h0)) u_a (
      .clock(clock), .clear(clear), .bus(a_if));
   fetch_unit #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0)) u_b (
      .clock(clock), .clear(clear), .bus(b_if));
   fetch_unit #(.DEPTH(2), .ADDR_W(8), .RESET_PC(32'hFFFF_FFF8)) u_c (
      .clock(clock), .clear(clear), .bus(c_if));

   function automatic logic [31:0] word(input logic [7:0] a);
      return 32'hC0DE_0000 | {24'h0, a};
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Registered-read instruction RAM models
   always @(posedge clock) begin
      if (a_if.imem_req) a_if.imem_rdata <= word(a_if.imem_addr);
      if (b_if.imem_req) b_if.imem_rdata <= word(b_if.imem_addr);
      if (c_if.imem_req) c_if.imem_rdata <= word(c_if.imem_addr);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Leaves the bench in cycle 0 (first cycle after clear release)
   task automatic do_reset(input logic rdy);
      clear = 1'b1;
      a_if.out_ready = rdy; b_if.out_ready = rdy; c_if.out_ready = rdy;
      a_if.redirect_valid = 1'b0; b_if.redirect_valid = 1'b0; c_if.redirect_valid = 1'b0;
      a_if.redirect_pc = '0; b_if.redirect_pc = '0; c_if.redirect_pc = '0;
      step();
      step();
      clear = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0 || a_if.imem_req !== 1'b0 || a_if.fifo_count !== 2'd0 ||
          a_if.out_instr !== 32'h0 || a_if.out_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b req=%b cnt=%0d instr=%h pc=%h, want all 0",
                  a_if.out_valid, a_if.imem_req, a_if.fifo_count, a_if.out_instr, a_if.out_pc);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (a_if.imem_req !== 1'b1 || a_if.imem_addr !== 8'(4*c)) begin
            miscompares++;
            $display("FAIL stream_req c%0d: got req=%b addr=%h, want req=1 addr=%h",
                     c, a_if.imem_req, a_if.imem_addr, 8'(4*c));
         end
         vectors++;
         if (c < 2) begin
            if (a_if.out_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL stream_early c%0d: got valid=%b, want 0", c, a_if.out_valid);
            end
         end else if (a_if.out_valid !== 1'b1 || a_if.out_pc !== 32'(4*(c-2)) ||
                      a_if.out_instr !== word(8'(4*(c-2)))) begin
            miscompares++;
            $display("FAIL stream_out c%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", c,
                     a_if.out_valid, a_if.out_pc, a_if.out_instr, 32'(4*(c-2)),
                     word(8'(4*(c-2))));
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic       exp_req [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [7:0] exp_addr[2] = '{8'h00, 8'h04};
      do_reset(1'b0);
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (a_if.imem_req !== exp_req[c] || (c < 2 && a_if.imem_addr !== exp_addr[c])) begin
            miscompares++;
            $display("FAIL stall_req c%0d: got req=%b addr=%h, want req=%b", c, a_if.imem_req,
                     a_if.imem_addr, exp_req[c]);
         end
         step();
      end
      vectors++;
      if (a_if.fifo_count !== 2'd2 || a_if.out_pc !== 32'h0 || a_if.out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_full: got cnt=%0d pc=%h valid=%b, want 2 00000000 1",
                  a_if.fifo_count, a_if.out_pc, a_if.out_valid);
      end
      // One-cycle release frees exactly one credit
      a_if.out_ready = 1'b1;
      #1;
      vectors++;
      if (a_if.imem_req !== 1'b1 || a_if.imem_addr !== 8'h08) begin
         miscompares++;
         $display("FAIL release_req: got req=%b addr=%h, want 1 08", a_if.imem_req,
                  a_if.imem_addr);
      end
      step();
      a_if.out_ready = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         vectors++;
         if (a_if.imem_req !== 1'b0 || a_if.out_pc !== 32'h4) begin
            miscompares++;
            $display("FAIL release_after %0d: got req=%b pc=%h, want 0 00000004", c,
                     a_if.imem_req, a_if.out_pc);
         end
         step();
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b0);
      step(); step(); step();
      b_if.redirect_valid = 1'b1;
      b_if.redirect_pc    = 32'h40;
      #1;
      vectors++;
      if (b_if.imem_req !== 1'b0 || b_if.fifo_count !== 3'd2) begin
         miscompares++;
         $display("FAIL redir_R: got req=%b cnt=%0d, want 0 2", b_if.imem_req, b_if.fifo_count);
      end
      step();
      b_if.redirect_valid = 1'b0;
      #1;
      vectors++;
      if (b_if.fifo_count !== 3'd0 || b_if.out_valid !== 1'b0 || b_if.imem_req !== 1'b1 ||
          b_if.imem_addr !== 8'h40) begin
         miscompares++;
         $display("FAIL redir_R1: got cnt=%0d valid=%b req=%b addr=%h, want 0 0 1 40",
                  b_if.fifo_count, b_if.out_valid, b_if.imem_req, b_if.imem_addr);
      end
`ifdef FETCH_PERF_EN
      vectors++;
      if (b_if.perf_flushed !== 32'd3 || b_if.perf_stall !== 32'd2) begin
         miscompares++;
         $display("FAIL perf_redir: got flushed=%0d stall=%0d, want 3 2", b_if.perf_flushed,
                  b_if.perf_stall);
      end
`endif
      step();
      vectors++;
      if (b_if.out_valid !== 1'b0 || b_if.imem_addr !== 8'h44) begin
         miscompares++;
         $display("FAIL redir_R2: got valid=%b addr=%h, want 0 44", b_if.out_valid,
                  b_if.imem_addr);
      end
      step();
      vectors++;
      if (b_if.out_valid !== 1'b1 || b_if.out_pc !== 32'h40 || b_if.out_instr !== word(8'h40))
      begin
         miscompares++;
         $display("FAIL redir_R3: got valid=%b pc=%h instr=%h, want 1 00000040 %h",
                  b_if.out_valid, b_if.out_pc, b_if.out_instr, word(8'h40));
      end
   endtask

   task automatic test_redirect_handshake();
      do_reset(1'b1);
      step(); step(); step();
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h80;
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b1 || a_if.out_pc !== 32'h4 || a_if.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL hs_R: got valid=%b pc=%h req=%b, want 1 00000004 0", a_if.out_valid,
                  a_if.out_pc, a_if.imem_req);
      end
      step();
      a_if.redirect_valid = 1'b0;
      #1;
      vectors++;
      if (a_if.fifo_count !== 2'd0 || a_if.out_valid !== 1'b0 || a_if.imem_addr !== 8'h80) begin
         miscompares++;
         $display("FAIL hs_R1: got cnt=%0d valid=%b addr=%h, want 0 0 80", a_if.fifo_count,
                  a_if.out_valid, a_if.imem_addr);
      end
      step(); step();
      vectors++;
      if (a_if.out_valid !== 1'b1 || a_if.out_pc !== 32'h80 || a_if.out_instr !== word(8'h80))
      begin
         miscompares++;
         $display("FAIL hs_R3: got valid=%b pc=%h instr=%h, want 1 00000080 %h",
                  a_if.out_valid, a_if.out_pc, a_if.out_instr, word(8'h80));
      end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      step(); step(); step();
      a_if.redirect_valid = 1'b1;
      a_if.redirect_pc    = 32'h20;
      step();
      a_if.redirect_pc    = 32'h33;
      #1;
      vectors++;
      if (a_if.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_second: got req=%b, want 0", a_if.imem_req);
      end
      step();
      a_if.redirect_valid = 1'b0;
      #1;
      vectors++;
      if (a_if.imem_req !== 1'b1 || a_if.imem_addr !== 8'h30 || a_if.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_R1: got req=%b addr=%h valid=%b, want 1 30 0", a_if.imem_req,
                  a_if.imem_addr, a_if.out_valid);
      end
      step(); step();
      vectors++;
      if (a_if.out_valid !== 1'b1 || a_if.out_pc !== 32'h30) begin
         miscompares++;
         $display("FAIL b2b_R3: got valid=%b pc=%h, want 1 00000030", a_if.out_valid,
                  a_if.out_pc);
      end
   endtask

   task automatic test_pc_wrap();
      logic [7:0]  exp_addr[3] = '{8'hF8, 8'hFC, 8'h00};
      logic [31:0] exp_pc  [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      do_reset(1'b1);
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            vectors++;
            if (c_if.imem_addr !== exp_addr[c]) begin
               miscompares++;
               $display("FAIL wrap_addr c%0d: got %h, want %h", c, c_if.imem_addr, exp_addr[c]);
            end
         end
         if (c >= 2) begin
            vectors++;
            if (c_if.out_valid !== 1'b1 || c_if.out_pc !== exp_pc[c-2] ||
                c_if.out_instr !== word(exp_addr[c-2])) begin
               miscompares++;
               $display("FAIL wrap_out c%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", c,
                        c_if.out_valid, c_if.out_pc, c_if.out_instr, exp_pc[c-2],
                        word(exp_addr[c-2]));
            end
         end
         step();
      end
   endtask

   task automatic test_async_clear();
      do_reset(1'b0);
      step(); step(); step(); step();
      vectors++;
      if (a_if.fifo_count !== 2'd2) begin
         miscompares++;
         $display("FAIL clr_pre: got cnt=%0d, want 2", a_if.fifo_count);
      end
      #2;
      clear = 1'b1;
      #1;
      vectors++;
      if (a_if.out_valid !== 1'b0 || a_if.imem_req !== 1'b0 || a_if.fifo_count !== 2'd0) begin
         miscompares++;
         $display("FAIL clr_async: got valid=%b req=%b cnt=%0d, want 0 0 0", a_if.out_valid,
                  a_if.imem_req, a_if.fifo_count);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_handshake();
      test_back_to_back();
      test_pc_wrap();
      test_async_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
